// File: rtl/reg_shift_pkg.sv
// Shared definitions for the iterative shift unit.
// Op codes, FSM state encoding, default data width and a decode helper.
// Optional feature macro: SHIFT_ROTATE_EN (ROL/ROR decode as rotates when defined,
// as NOP otherwise).
package reg_shift_pkg;

    localparam int unsigned WIDTH_DEF = 32;
    localparam int unsigned OP_W      = 3;

    localparam logic [OP_W-1:0] OP_NOP  = 3'b000;
    localparam logic [OP_W-1:0] OP_LOAD = 3'b001;
    localparam logic [OP_W-1:0] OP_SLL  = 3'b010;
    localparam logic [OP_W-1:0] OP_SRL  = 3'b011;
    localparam logic [OP_W-1:0] OP_SRA  = 3'b100;
    localparam logic [OP_W-1:0] OP_ROL  = 3'b101;
    localparam logic [OP_W-1:0] OP_ROR  = 3'b110;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_e;

    // True for ops that iterate in SHIFT; rotates only count when built in.
    function automatic logic is_shift_op(input logic [OP_W-1:0] op);
        logic r;
        r = 1'b0;
        case (op)
            OP_SLL, OP_SRL, OP_SRA: r = 1'b1;
`ifdef SHIFT_ROTATE_EN
            OP_ROL, OP_ROR:         r = 1'b1;
`endif
            default:                r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/reg_shift_step.sv
// Combinational single-bit shift of the held data word.
// Ports: op (operation code), data (current value), shifted_c (value after one step).
// Optional feature macro: SHIFT_ROTATE_EN (adds ROL/ROR paths; otherwise they pass data through).
module reg_shift_step
    import reg_shift_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF
) (
    input  logic [OP_W-1:0]  op,
    input  logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] shifted_c
);

    // One-bit step per op; unknown/non-shift ops leave the data unchanged.
    always_comb begin
        shifted_c = data;
        case (op)
            OP_SLL: shifted_c = {data[WIDTH-2:0], 1'b0};
            OP_SRL: shifted_c = {1'b0, data[WIDTH-1:1]};
            OP_SRA: shifted_c = {data[WIDTH-1], data[WIDTH-1:1]};
`ifdef SHIFT_ROTATE_EN
            OP_ROL: shifted_c = {data[WIDTH-2:0], data[WIDTH-1]};
            OP_ROR: shifted_c = {data[0], data[WIDTH-1:1]};
`endif
            default: shifted_c = data;
        endcase
    end

endmodule

// File: rtl/reg_shift_seq.sv
// Registered iterative shift unit: LOAD captures an operand, shift ops move the held
// value one bit per cycle under a start/busy/done handshake.
// Ports: clk, reset (sync, active-high), start, op, src, amt -> busy, done, out.
// Optional feature macro: SHIFT_ROTATE_EN (enables ROL/ROR; otherwise they act as NOP).
module reg_shift_seq
    import reg_shift_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [OP_W-1:0]           op,
    input  logic [WIDTH-1:0]          src,
    input  logic [$clog2(WIDTH)-1:0]  amt,
    output logic                      busy,
    output logic                      done,
    output logic [WIDTH-1:0]          out
);

    localparam int unsigned AMT_W = $clog2(WIDTH);

    state_e             state_q, state_d;
    logic [OP_W-1:0]    op_q, op_d;
    logic [AMT_W-1:0]   count_q, count_d;
    logic [WIDTH-1:0]   out_q, out_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   step_c;

    reg_shift_step #(.WIDTH(WIDTH)) u_step (
        .op        (op_q),
        .data      (out_q),
        .shifted_c (step_c)
    );

    // Next-state, counter and data-register update.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        count_d = count_q;
        out_d   = out_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d    = op;
                    count_d = amt;
                    if (op == OP_LOAD) begin
                        out_d = src;
                    end
                    // Zero-length shifts and non-shift ops complete next cycle.
                    if (is_shift_op(op) && (amt != '0)) begin
                        state_d = S_SHIFT;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_SHIFT: begin
                out_d   = step_c;
                count_d = count_q - AMT_W'(1);
                if (count_q == AMT_W'(1)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        // Handshake flags are registered copies of the next-state decode.
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            op_q    <= OP_NOP;
            count_q <= '0;
            out_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            count_q <= count_d;
            out_q   <= out_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign out  = out_q;

endmodule

// File: tb/tb_reg_shift_seq.sv
// Self-checking bench for reg_shift_seq: a 32-bit and an 8-bit instance driven with
// directed and random ops, checked against an arithmetic reference model.
// Honours SHIFT_ROTATE_EN the same way as the design.
module tb_reg_shift_seq;

    localparam logic [2:0] T_NOP  = 3'b000;
    localparam logic [2:0] T_LOAD = 3'b001;
    localparam logic [2:0] T_SLL  = 3'b010;
    localparam logic [2:0] T_SRL  = 3'b011;
    localparam logic [2:0] T_SRA  = 3'b100;
    localparam logic [2:0] T_ROL  = 3'b101;
    localparam logic [2:0] T_ROR  = 3'b110;
    localparam logic [2:0] T_NOP7 = 3'b111;

    logic        clk = 1'b0;
    logic        reset;

    logic        start32, busy32, done32;
    logic [2:0]  op32;
    logic [31:0] src32, out32;
    logic [4:0]  amt32;

    logic        start8, busy8, done8;
    logic [2:0]  op8;
    logic [7:0]  src8, out8;
    logic [2:0]  amt8;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] mod_out [2];

    always #5 clk = ~clk;

    reg_shift_seq #(.WIDTH(32)) dut32 (
        .clk(clk), .reset(reset), .start(start32), .op(op32), .src(src32), .amt(amt32),
        .busy(busy32), .done(done32), .out(out32)
    );

    reg_shift_seq #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .start(start8), .op(op8), .src(src8), .amt(amt8),
        .busy(busy8), .done(done8), .out(out8)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic bit rot_en();
`ifdef SHIFT_ROTATE_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    function automatic bit iterates(input logic [2:0] o);
        return (o == T_SLL) || (o == T_SRL) || (o == T_SRA) ||
               (rot_en() && ((o == T_ROL) || (o == T_ROR)));
    endfunction

    // Final value of an op applied as a whole to v, w bits wide.
    function automatic logic [31:0] model(input int w, input logic [2:0] o,
                                          input logic [31:0] v, input logic [31:0] s,
                                          input int a);
        logic [63:0] m;
        logic [63:0] x;
        logic [63:0] r;
        m = (64'd1 << w) - 64'd1;
        x = {32'd0, v} & m;
        r = x;
        case (o)
            T_LOAD: r = {32'd0, s} & m;
            T_SLL:  r = (x << a) & m;
            T_SRL:  r = x >> a;
            T_SRA:  r = x[w-1] ? ((x >> a) | (m & ~(m >> a))) : (x >> a);
            T_ROL:  if (rot_en() && a != 0) r = ((x << a) | (x >> (w - a))) & m;
            T_ROR:  if (rot_en() && a != 0) r = ((x >> a) | (x << (w - a))) & m;
            default: r = x;
        endcase
        return r[31:0];
    endfunction

    task automatic drive(input bit w8, input logic st, input logic [2:0] o,
                         input logic [31:0] s, input int a);
        if (w8) begin
            start8 = st; op8 = o; src8 = s[7:0]; amt8 = 3'(a);
        end else begin
            start32 = st; op32 = o; src32 = s; amt32 = 5'(a);
        end
    endtask

    // Issue one op in the next cycle and check busy/done/latency/result.
    task automatic run_op(input bit w8, input logic [2:0] o, input logic [31:0] s,
                          input int a, input bit pulse);
        int          w;
        int          lat;
        int          exp_lat;
        bit          seen;
        logic [31:0] exp_out;
        w = w8 ? 8 : 32;
        @(negedge clk);
        chk("idle_busy", 64'(w8 ? busy8 : busy32), 64'd0);
        chk("idle_done", 64'(w8 ? done8 : done32), 64'd0);
        drive(w8, 1'b1, o, s, a);
        exp_out = model(w, o, mod_out[w8], s, a);
        exp_lat = (iterates(o) && a != 0) ? a + 1 : 1;
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < 80) begin
            @(negedge clk);
            lat++;
            if (w8 ? done8 : done32) seen = 1'b1;
            else if (pulse) drive(w8, 1'b1, 3'($urandom), $urandom, int'($urandom_range(0, 31)));
            else drive(w8, 1'b0, T_NOP, 32'd0, 0);
        end
        drive(w8, 1'b0, T_NOP, 32'd0, 0);
        chk("latency", 64'(lat), 64'(exp_lat));
        chk("out", 64'(w8 ? {24'd0, out8} : out32), 64'(exp_out));
        chk("busy_at_done", 64'(w8 ? busy8 : busy32), 64'd1);
        mod_out[w8] = exp_out;
    endtask

    task automatic reset_mid_shift();
        int dones;
        run_op(1'b0, T_LOAD, 32'hF0F0_F0F0, 0, 1'b0);
        @(negedge clk);
        drive(1'b0, 1'b1, T_SLL, 32'd0, 20);
        repeat (5) begin
            @(negedge clk);
            drive(1'b0, 1'b0, T_NOP, 32'd0, 0);
        end
        reset = 1'b1;
        drive(1'b0, 1'b1, T_LOAD, 32'hDEAD_BEEF, 3);
        @(negedge clk);
        chk("rst_mid_out", 64'(out32), 64'd0);
        chk("rst_mid_busy", 64'(busy32), 64'd0);
        chk("rst_mid_done", 64'(done32), 64'd0);
        reset = 1'b0;
        drive(1'b0, 1'b0, T_NOP, 32'd0, 0);
        mod_out[0] = 32'd0;
        mod_out[1] = 32'd0;
        dones = 0;
        repeat (25) begin
            @(negedge clk);
            if (done32) dones++;
        end
        chk("rst_no_done", 64'(dones), 64'd0);
        chk("rst_idle_busy", 64'(busy32), 64'd0);
    endtask

    initial begin
        reset = 1'b1;
        drive(1'b0, 1'b0, T_NOP, 32'd0, 0);
        drive(1'b1, 1'b0, T_NOP, 32'd0, 0);
        mod_out[0] = 32'd0;
        mod_out[1] = 32'd0;
        repeat (3) @(negedge clk);
        chk("rst_out32", 64'(out32), 64'd0);
        chk("rst_busy32", 64'(busy32), 64'd0);
        chk("rst_done32", 64'(done32), 64'd0);
        chk("rst_out8", 64'(out8), 64'd0);
        chk("rst_busy8", 64'(busy8), 64'd0);
        chk("rst_done8", 64'(done8), 64'd0);
        reset = 1'b0;

        // Load then logical right shift.
        run_op(1'b0, T_LOAD, 32'h8000_0001, 0, 1'b0);
        run_op(1'b0, T_SRL, 32'd0, 4, 1'b0);
        chk("srl4_value", 64'(out32), 64'h0800_0000);

        // Full-range arithmetic shift and zero-length shift.
        run_op(1'b0, T_LOAD, 32'h8000_0000, 0, 1'b0);
        run_op(1'b0, T_SRA, 32'd0, 31, 1'b0);
        chk("sra31_value", 64'(out32), 64'hFFFF_FFFF);
        run_op(1'b0, T_SLL, 32'd0, 0, 1'b0);

        // start held high while busy; the following op goes back-to-back.
        run_op(1'b0, T_LOAD, 32'h0000_00A5, 0, 1'b0);
        run_op(1'b0, T_SLL, 32'h1234_5678, 8, 1'b1);
        chk("pulse_value", 64'(out32), 64'h0000_A500);
        run_op(1'b0, T_SRL, 32'd0, 1, 1'b0);

        // Rotates (or NOP when not built in).
        run_op(1'b0, T_LOAD, 32'h0000_0001, 0, 1'b0);
        run_op(1'b0, T_ROL, 32'd0, 1, 1'b0);
        run_op(1'b0, T_LOAD, 32'h0000_0001, 0, 1'b0);
        run_op(1'b0, T_ROR, 32'd0, 1, 1'b0);
        run_op(1'b0, T_NOP7, 32'hFFFF_FFFF, 9, 1'b0);

        // Narrow instance.
        run_op(1'b1, T_LOAD, 32'h0000_0081, 0, 1'b0);
        run_op(1'b1, T_SRA, 32'd0, 7, 1'b0);
        chk("w8_sra7_value", 64'(out8), 64'h0000_00FF);
        run_op(1'b1, T_NOP7, 32'h0000_0055, 5, 1'b0);

        reset_mid_shift();

        // Random ops on both widths.
        for (int i = 0; i < 60; i++) begin
            bit w8;
            w8 = 1'($urandom_range(0, 1));
            run_op(w8, 3'($urandom), $urandom,
                   int'($urandom_range(0, w8 ? 7 : 31)), 1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
